// File: rtl/ethertype_parser_if.sv
// Receive-path stream into the EtherType classifier and the classified payload stream out of it.
// master drives the frame stream, slave is the parser.
interface ethertype_parser_if #(
   parameter int N          = 2,
   parameter int VLAN_DEPTH = 1
);
   localparam int VW = (VLAN_DEPTH > 0) ? $clog2(VLAN_DEPTH + 1) : 1;

   logic [N-1:0]  axiid;
   logic          axiiv;
   logic          type_valid;
   logic [1:0]    type_class;
   logic [VW-1:0] vlan_count;
   logic [11:0]   vlan_id;
   logic          axiov;
   logic [N-1:0]  axiod;

   modport master (
      output axiid, axiiv,
      input  type_valid, type_class, vlan_count, vlan_id, axiov, axiod
   );

   modport slave (
      input  axiid, axiiv,
      output type_valid, type_class, vlan_count, vlan_id, axiov, axiod
   );
endinterface

// File: rtl/ethertype_parser.sv
// EtherType classifier: skips up to VLAN_DEPTH stacked tags, classifies the final type,
// forwards the payload one cycle late. A low axiiv cycle ends the frame and clears everything.
module ethertype_parser #(
   parameter int N          = 2,
   parameter int VLAN_DEPTH = 1
) (
   input  logic               clk,
   input  logic               rst,
   ethertype_parser_if.slave  s
);
   localparam int BEATS = 16 / N;
   localparam int CW    = $clog2(BEATS) + 1;
   localparam int VW    = (VLAN_DEPTH > 0) ? $clog2(VLAN_DEPTH + 1) : 1;

   typedef enum logic [1:0] {FIELD, TCI, PAYLOAD} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] bcnt_q, bcnt_d;
   logic [15:0]   fld_q, fld_d;
   logic          tv_q, tv_d;
   logic [1:0]    tc_q, tc_d;
   logic [VW-1:0] vc_q, vc_d;
   logic [11:0]   vid_q, vid_d;
   logic          ov_q, ov_d;
   logic [N-1:0]  od_q, od_d;

   // Shifting in MSB-first leaves the first beat of a field in the top bits once BEATS beats arrive.
   logic [15+N:0] shifted;
   logic [15:0]   fld_full;
   logic          last_beat;
   logic          is_tpid;
   logic          tag_room;
   logic [1:0]    cls;

   always_comb begin
      shifted   = {fld_q, s.axiid};
      fld_full  = shifted[15:0];
      last_beat = (bcnt_q == CW'(BEATS - 1));
      is_tpid   = (fld_full == 16'h8100) || (fld_full == 16'h88A8);
      tag_room  = (VLAN_DEPTH > 0) && (int'(vc_q) < VLAN_DEPTH);
      case (fld_full)
         16'h0800: cls = 2'd0;
         16'h0806: cls = 2'd1;
         16'h86DD: cls = 2'd2;
         default:  cls = 2'd3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FIELD;
         bcnt_q  <= '0;
         fld_q   <= '0;
         tv_q    <= 1'b0;
         tc_q    <= '0;
         vc_q    <= '0;
         vid_q   <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         fld_q   <= fld_d;
         tv_q    <= tv_d;
         tc_q    <= tc_d;
         vc_q    <= vc_d;
         vid_q   <= vid_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!s.axiiv) begin
         state_d = FIELD;
      end else begin
         case (state_q)
            FIELD:   if (last_beat) state_d = (is_tpid && tag_room) ? TCI : PAYLOAD;
            TCI:     if (last_beat) state_d = FIELD;
            PAYLOAD: state_d = PAYLOAD;
            default: state_d = FIELD;
         endcase
      end
   end

   always_comb begin
      bcnt_d = bcnt_q;
      fld_d  = fld_q;
      tv_d   = tv_q;
      tc_d   = tc_q;
      vc_d   = vc_q;
      vid_d  = vid_q;
      ov_d   = 1'b0;
      od_d   = '0;
      if (!s.axiiv) begin
         bcnt_d = '0;
         fld_d  = '0;
         tv_d   = 1'b0;
         tc_d   = '0;
         vc_d   = '0;
         vid_d  = '0;
      end else begin
         case (state_q)
            FIELD, TCI: begin
               fld_d  = fld_full;
               bcnt_d = last_beat ? '0 : bcnt_q + CW'(1);
               if (last_beat && state_q == FIELD) begin
                  if (is_tpid && tag_room) begin
                     vc_d = vc_q + VW'(1);
                  end else begin
                     tv_d = 1'b1;
                     tc_d = cls;
                  end
               end
               // vc_q is already 1 while the outermost tag's TCI is being collected.
               if (last_beat && state_q == TCI && vc_q == VW'(1)) vid_d = fld_full[11:0];
            end
            PAYLOAD: begin
               ov_d = 1'b1;
               od_d = s.axiid;
            end
            default: ;
         endcase
      end
   end

   assign s.type_valid = tv_q;
   assign s.type_class = tc_q;
   assign s.vlan_count = vc_q;
   assign s.vlan_id    = vid_q;
   assign s.axiov      = ov_q;
   assign s.axiod      = od_q;
endmodule

// File: tb/tb_ethertype_parser.sv
// Bench for ethertype_parser: one N=2/VLAN_DEPTH=1 instance and one N=8/VLAN_DEPTH=2 instance,
// directed frames plus random frames against a word-level frame model.
module tb_ethertype_parser;
   typedef bit [15:0] q16_t[$];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ethertype_parser_if #(.N(2), .VLAN_DEPTH(1)) ifa();
   ethertype_parser_if #(.N(8), .VLAN_DEPTH(2)) ifb();

   ethertype_parser #(.N(2), .VLAN_DEPTH(1)) dut_a (.clk(clk), .rst(rst), .s(ifa.slave));
   ethertype_parser #(.N(8), .VLAN_DEPTH(2)) dut_b (.clk(clk), .rst(rst), .s(ifb.slave));

   int n_checks = 0;
   int n_fail   = 0;
   int last_tv, last_tc, last_vc, last_vid;

   function automatic int dut_n(int d);
      return (d == 0) ? 2 : 8;
   endfunction

   function automatic int dut_depth(int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic int type_of(int w);
      case (w)
         16'h0800: return 0;
         16'h0806: return 1;
         16'h86DD: return 2;
         default:  return 3;
      endcase
   endfunction

   function automatic int word_at(q16_t b, int n, int p);
      int w = 0;
      for (int k = 0; k < 16 / n; k++) w = (w << n) | int'(b[p * (16 / n) + k]);
      return w;
   endfunction

   task automatic drive(int d, bit v, bit [15:0] dat);
      if (d == 0) begin
         ifa.axiiv = v; ifa.axiid = dat[1:0];
         ifb.axiiv = 1'b0; ifb.axiid = '0;
      end else begin
         ifb.axiiv = v; ifb.axiid = dat[7:0];
         ifa.axiiv = 1'b0; ifa.axiid = '0;
      end
   endtask

   task automatic sample(int d, output int tv, output int tc, output int vc,
                         output int vid, output int ov, output int od);
      if (d == 0) begin
         tv = int'(ifa.type_valid); tc = int'(ifa.type_class); vc = int'(ifa.vlan_count);
         vid = int'(ifa.vlan_id); ov = int'(ifa.axiov); od = int'(ifa.axiod);
      end else begin
         tv = int'(ifb.type_valid); tc = int'(ifb.type_class); vc = int'(ifb.vlan_count);
         vid = int'(ifb.vlan_id); ov = int'(ifb.axiov); od = int'(ifb.axiod);
      end
   endtask

   task automatic to_beats(int n, q16_t words, output q16_t beats);
      beats = {};
      foreach (words[j])
         for (int k = 0; k < 16 / n; k++)
            beats.push_back((words[j] >> (16 - n * (k + 1))) & 16'((1 << n) - 1));
   endtask

   // Drives one frame then one idle cycle, checking every cycle against the word-level model.
   task automatic run_frame(int d, q16_t beats, string tag);
      int n = dut_n(d), b = 16 / n, depth = dut_depth(d), len = beats.size();
      int hdr = -1, cls = -1, vidv = 0, vid = 0, vidend = 0, p = 0, tags = 0, w;
      int tagend[$];
      bit done = 0;
      int got[6], exp[6];
      string nm[6] = '{"type_valid", "type_class", "vlan_count", "vlan_id", "axiov", "axiod"};
      while (!done) begin
         if ((p + 1) * b > len) begin
            done = 1;
         end else begin
            w = word_at(beats, n, p);
            if ((w == 16'h8100 || w == 16'h88A8) && tags < depth) begin
               tagend.push_back((p + 1) * b - 1);
               if (tags == 0 && (p + 2) * b <= len) begin
                  vidv = 1; vid = word_at(beats, n, p + 1) & 12'hFFF; vidend = (p + 2) * b - 1;
               end
               tags++; p += 2;
            end else begin
               cls = type_of(w); hdr = (p + 1) * b; done = 1;
            end
         end
      end
      for (int i = 0; i < len; i++) begin
         drive(d, 1'b1, beats[i]);
         @(posedge clk); #1;
         sample(d, got[0], got[1], got[2], got[3], got[4], got[5]);
         exp[0] = (cls >= 0 && i >= hdr - 1) ? 1 : 0;
         exp[1] = exp[0] ? cls : 0;
         exp[2] = 0;
         foreach (tagend[t]) if (tagend[t] <= i) exp[2]++;
         exp[3] = (vidv && i >= vidend) ? vid : 0;
         exp[4] = (cls >= 0 && i >= hdr) ? 1 : 0;
         exp[5] = exp[4] ? int'(beats[i]) : 0;
         for (int j = 0; j < 6; j++) begin
            n_checks++;
            if (got[j] !== exp[j]) begin
               n_fail++;
               $display("FAIL %s %s beat %0d: got %0d expected %0d", tag, nm[j], i, got[j], exp[j]);
            end
         end
         last_tv = got[0]; last_tc = got[1]; last_vc = got[2]; last_vid = got[3];
      end
      drive(d, 1'b0, 16'h0);
      @(posedge clk); #1;
      sample(d, got[0], got[1], got[2], got[3], got[4], got[5]);
      for (int j = 0; j < 6; j++) begin
         n_checks++;
         if (got[j] !== 0) begin
            n_fail++;
            $display("FAIL %s gap %s: got %0d expected 0", tag, nm[j], got[j]);
         end
      end
   endtask

   task automatic test_reset();
      int o[6];
      rst = 1'b1;
      drive(0, 1'b0, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         sample(d, o[0], o[1], o[2], o[3], o[4], o[5]);
         for (int j = 0; j < 6; j++) begin
            n_checks++;
            if (o[j] !== 0) begin
               n_fail++;
               $display("FAIL reset dut%0d output%0d: got %0d expected 0", d, j, o[j]);
            end
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_ipv4();
      q16_t bt;
      to_beats(2, '{16'h0800}, bt);
      bt.push_back(2); bt.push_back(2); bt.push_back(1); bt.push_back(1);
      run_frame(0, bt, "ipv4");
      n_checks++;
      if (last_tv !== 1 || last_tc !== 0 || last_vc !== 0) begin
         n_fail++;
         $display("FAIL ipv4 final: got tv=%0d tc=%0d vc=%0d expected 1 0 0", last_tv, last_tc, last_vc);
      end
   endtask

   task automatic test_vlan();
      q16_t bt;
      to_beats(2, '{16'h8100, 16'h6064, 16'h0806}, bt);
      bt.push_back(1); bt.push_back(0); bt.push_back(1); bt.push_back(1);
      run_frame(0, bt, "vlan");
      n_checks++;
      if (last_vc !== 1 || last_vid !== 12'h064 || last_tc !== 1) begin
         n_fail++;
         $display("FAIL vlan final: got vc=%0d vid=%0h tc=%0d expected 1 64 1", last_vc, last_vid, last_tc);
      end
   endtask

   task automatic test_tag_overflow();
      q16_t bt;
      to_beats(2, '{16'h88A8, 16'h0005, 16'h8100, 16'h0800}, bt);
      run_frame(0, bt, "overflow");
      n_checks++;
      if (last_tc !== 3 || last_vc !== 1 || last_vid !== 5) begin
         n_fail++;
         $display("FAIL overflow final: got tc=%0d vc=%0d vid=%0d expected 3 1 5", last_tc, last_vc, last_vid);
      end
   endtask

   task automatic test_back_to_back();
      q16_t bt;
      to_beats(8, '{16'h86DD, 16'h6000}, bt);
      run_frame(1, bt, "b2b_ipv6");
      n_checks++;
      if (last_tc !== 2) begin
         n_fail++;
         $display("FAIL b2b first class: got %0d expected 2", last_tc);
      end
      to_beats(8, '{16'h0800, 16'h4500}, bt);
      run_frame(1, bt, "b2b_ipv4");
      n_checks++;
      if (last_tc !== 0 || last_tv !== 1) begin
         n_fail++;
         $display("FAIL b2b second: got tc=%0d tv=%0d expected 0 1", last_tc, last_tv);
      end
   endtask

   task automatic test_truncation();
      q16_t bt = '{16'd0, 16'd0, 16'd2, 16'd0};
      run_frame(0, bt, "trunc");
      n_checks++;
      if (last_tv !== 0) begin
         n_fail++;
         $display("FAIL trunc type_valid: got %0d expected 0", last_tv);
      end
      to_beats(2, '{16'h0806, 16'h1234}, bt);
      run_frame(0, bt, "after_trunc");
      n_checks++;
      if (last_tv !== 1 || last_tc !== 1) begin
         n_fail++;
         $display("FAIL after_trunc: got tv=%0d tc=%0d expected 1 1", last_tv, last_tc);
      end
   endtask

   task automatic test_rst_midframe();
      q16_t bt;
      int o[6];
      to_beats(2, '{16'h0800, 16'hC3C3}, bt);
      for (int i = 0; i < 10; i++) begin
         drive(0, 1'b1, bt[i]);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      drive(0, 1'b1, bt[10]);
      @(posedge clk); #1;
      rst = 1'b0;
      sample(0, o[0], o[1], o[2], o[3], o[4], o[5]);
      for (int j = 0; j < 6; j++) begin
         n_checks++;
         if (o[j] !== 0) begin
            n_fail++;
            $display("FAIL rst_mid output%0d: got %0d expected 0", j, o[j]);
         end
      end
      for (int i = 11; i < 13; i++) begin
         drive(0, 1'b1, bt[i]);
         @(posedge clk); #1;
         sample(0, o[0], o[1], o[2], o[3], o[4], o[5]);
         n_checks++;
         if (o[0] !== 0 || o[4] !== 0) begin
            n_fail++;
            $display("FAIL rst_release beat %0d: got tv=%0d ov=%0d expected 0 0", i, o[0], o[4]);
         end
      end
      drive(0, 1'b0, 16'h0);
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      q16_t words, bt;
      int d, n, ntags, npay, cut;
      bit [15:0] et_pool[4] = '{16'h0800, 16'h0806, 16'h86DD, 16'h8100};
      for (int it = 0; it < 60; it++) begin
         d = it % 2;
         n = dut_n(d);
         words = {};
         ntags = $urandom_range(0, dut_depth(d) + 1);
         for (int t = 0; t < ntags; t++) begin
            words.push_back($urandom_range(0, 1) ? 16'h8100 : 16'h88A8);
            words.push_back(16'($urandom));
         end
         words.push_back($urandom_range(0, 3) == 3 ? 16'($urandom) : et_pool[$urandom_range(0, 3)]);
         to_beats(n, words, bt);
         npay = $urandom_range(0, 6);
         for (int k = 0; k < npay; k++) bt.push_back(16'($urandom) & 16'((1 << n) - 1));
         if ($urandom_range(0, 4) == 0 && bt.size() > 1) begin
            cut = $urandom_range(1, bt.size() - 1);
            while (bt.size() > cut) void'(bt.pop_back());
         end
         run_frame(d, bt, "random");
      end
   endtask

   initial begin
      rst = 1'b0;
      ifa.axiiv = 1'b0; ifa.axiid = '0;
      ifb.axiiv = 1'b0; ifb.axiid = '0;
      @(posedge clk); #1;
      test_reset();
      test_ipv4();
      test_vlan();
      test_tag_overflow();
      test_back_to_back();
      test_truncation();
      test_rst_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
